// File: rtl/l1_bus_pkg.sv
// Shared definitions for the dcache miss interface: default geometry and the
// line-responder state encoding.
package l1_bus_pkg;

  localparam int DEF_ADDR_WIDTH   = 64;
  localparam int DEF_LINE_SIZE    = 512;
  localparam int DEF_BEAT_WIDTH   = 64;
  localparam int DEF_OFFSET_WIDTH = 6;
  localparam int L1_BEATS         = DEF_LINE_SIZE / DEF_BEAT_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_FILL = 2'd2,
    ST_RESP = 2'd3
  } l1_state_e;

endpackage

// File: rtl/l1_line_assembler.sv
// Beat counter plus beat-indexed line register; beats are written in order
// 0..BEATS-1 and the counter wraps after the last one.
module l1_line_assembler
  import l1_bus_pkg::*;
#(
  parameter int LINE_SIZE  = DEF_LINE_SIZE,
  parameter int BEAT_WIDTH = DEF_BEAT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_wr_en,
  input  logic [BEAT_WIDTH-1:0] i_beat_data,
  output logic                  o_last,
  output logic [LINE_SIZE-1:0]  o_line
);

  localparam int unsigned BEATS = LINE_SIZE / BEAT_WIDTH;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [CNT_W-1:0]     r_cnt;
  logic [LINE_SIZE-1:0] r_line;

  assign o_last = (r_cnt == CNT_W'(BEATS - 1));
  assign o_line = r_line;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_line <= '0;
    end else if (i_wr_en) begin
      for (int unsigned k = 0; k < BEATS; k++) begin
        if (r_cnt == CNT_W'(k)) r_line[k*BEAT_WIDTH +: BEAT_WIDTH] <= i_beat_data;
      end
      r_cnt <= o_last ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/l1_line_responder.sv
// Responder end of the dcache miss interface: accepts one line request, fetches
// it as a burst of beats from memory and returns the assembled line.
module l1_line_responder
  import l1_bus_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int LINE_SIZE    = DEF_LINE_SIZE,
  parameter int BEAT_WIDTH   = DEF_BEAT_WIDTH,
  parameter int OFFSET_WIDTH = DEF_OFFSET_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  l1req_vld_i,
  output logic                  l1req_ack_o,
  input  logic                  l1req_rd_i,
  input  logic [ADDR_WIDTH-1:0] l1req_addr_i,
  output logic                  resp_vld_o,
  output logic [LINE_SIZE-1:0]  resp_data_o,
  output logic                  mem_req_vld_o,
  input  logic                  mem_req_rdy_i,
  output logic [ADDR_WIDTH-1:0] mem_req_addr_o,
  input  logic                  mem_rdata_vld_i,
  input  logic [BEAT_WIDTH-1:0] mem_rdata_i,
  input  logic                  flush_i
);

  l1_state_e             r_state;
  l1_state_e             w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_drop;
  logic                  r_rd;
  logic                  w_wr_en;
  logic                  w_last;
  logic                  w_unused;

  // The write/read flavour of the miss never changes the fetch.
  assign w_unused = ^{l1req_addr_i[OFFSET_WIDTH-1:0], r_rd};

  always_comb begin
    w_next        = r_state;
    l1req_ack_o   = 1'b0;
    mem_req_vld_o = 1'b0;
    resp_vld_o    = 1'b0;
    w_wr_en       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (l1req_vld_i && !flush_i) begin
          l1req_ack_o = 1'b1;
          w_next      = ST_REQ;
        end
      end
      ST_REQ: begin
        mem_req_vld_o = 1'b1;
        if (mem_req_rdy_i)  w_next = ST_FILL;
        else if (flush_i)   w_next = ST_IDLE;
      end
      ST_FILL: begin
        w_wr_en = mem_rdata_vld_i;
        if (mem_rdata_vld_i && w_last) w_next = ST_RESP;
      end
      ST_RESP: begin
        resp_vld_o = !r_drop && !flush_i;
        w_next     = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
    // Keep every handshake output quiet while reset is asserted.
    if (rst) begin
      l1req_ack_o   = 1'b0;
      mem_req_vld_o = 1'b0;
      resp_vld_o    = 1'b0;
      w_wr_en       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_drop  <= 1'b0;
      r_rd    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (l1req_ack_o) begin
        r_addr <= {l1req_addr_i[ADDR_WIDTH-1:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
        r_rd   <= l1req_rd_i;
      end
      // A flush after the burst is accepted still drains the beats, but the line is dropped.
      case (r_state)
        ST_REQ:  if (mem_req_rdy_i) r_drop <= flush_i;
        ST_FILL: if (flush_i) r_drop <= 1'b1;
        ST_RESP: r_drop <= 1'b0;
        default: ;
      endcase
    end
  end

  assign mem_req_addr_o = r_addr;

  l1_line_assembler #(
    .LINE_SIZE  (LINE_SIZE),
    .BEAT_WIDTH (BEAT_WIDTH)
  ) u_asm (
    .clk         (clk),
    .rst         (rst),
    .i_wr_en     (w_wr_en),
    .i_beat_data (mem_rdata_i),
    .o_last      (w_last),
    .o_line      (resp_data_o)
  );

endmodule

// File: tb/tb_l1_line_responder.sv
// Randomized bench for l1_line_responder with a transaction-level reference model
// checked every cycle, plus directed scenarios with hand-computed expectations.
module tb_l1_line_responder;

  localparam int AW = 64;
  localparam int LS = 512;
  localparam int BW = 64;
  localparam int NB = LS / BW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          l1req_vld_i = 1'b0;
  logic          l1req_ack_o;
  logic          l1req_rd_i = 1'b0;
  logic [AW-1:0] l1req_addr_i = '0;
  logic          resp_vld_o;
  logic [LS-1:0] resp_data_o;
  logic          mem_req_vld_o;
  logic          mem_req_rdy_i = 1'b0;
  logic [AW-1:0] mem_req_addr_o;
  logic          mem_rdata_vld_i = 1'b0;
  logic [BW-1:0] mem_rdata_i = '0;
  logic          flush_i = 1'b0;

  always #5 clk = ~clk;

  l1_line_responder #(
    .ADDR_WIDTH   (AW),
    .LINE_SIZE    (LS),
    .BEAT_WIDTH   (BW),
    .OFFSET_WIDTH (6)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .l1req_vld_i     (l1req_vld_i),
    .l1req_ack_o     (l1req_ack_o),
    .l1req_rd_i      (l1req_rd_i),
    .l1req_addr_i    (l1req_addr_i),
    .resp_vld_o      (resp_vld_o),
    .resp_data_o     (resp_data_o),
    .mem_req_vld_o   (mem_req_vld_o),
    .mem_req_rdy_i   (mem_req_rdy_i),
    .mem_req_addr_o  (mem_req_addr_o),
    .mem_rdata_vld_i (mem_rdata_vld_i),
    .mem_rdata_i     (mem_rdata_i),
    .flush_i         (flush_i)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int dut_resp_cnt = 0;
  int dut_hs_cnt = 0;
  int dut_ack_cyc = -1;
  int dut_resp_cyc = -1;
  logic [AW-1:0] last_hs_addr;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [LS-1:0] act, input logic [LS-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Reference model: where the outstanding request is (0 none, 1 awaiting burst
  // acceptance, 2 collecting beats, 3 returning), plus the beats collected so far.
  int            m_ph = 0;
  int            m_got = 0;
  bit            m_drop = 0;
  logic [AW-1:0] m_addr = '0;
  logic [BW-1:0] m_beats [NB];

  initial begin : compare
    logic e_ack, e_mreq, e_resp;
    logic [LS-1:0] e_line;
    for (int i = 0; i < NB; i++) m_beats[i] = '0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      e_ack  = !rst && m_ph == 0 && l1req_vld_i && !flush_i;
      e_mreq = !rst && m_ph == 1;
      e_resp = !rst && m_ph == 3 && !m_drop && !flush_i;
      for (int i = 0; i < NB; i++) e_line[i*BW +: BW] = m_beats[i];
      chk("ack", l1req_ack_o, e_ack);
      chk("mem_req_vld", mem_req_vld_o, e_mreq);
      chk("mem_req_addr", mem_req_addr_o, m_addr);
      chk("resp_vld", resp_vld_o, e_resp);
      chk("resp_data", resp_data_o, e_line);
      if (l1req_ack_o) dut_ack_cyc = cyc;
      if (resp_vld_o) begin dut_resp_cnt++; dut_resp_cyc = cyc; end
      if (mem_req_vld_o && mem_req_rdy_i) dut_hs_cnt++;
      if (rst) begin
        m_ph = 0; m_got = 0; m_drop = 0; m_addr = '0;
        for (int i = 0; i < NB; i++) m_beats[i] = '0;
      end else begin
        case (m_ph)
          0: if (e_ack) begin m_addr = l1req_addr_i & ~64'h3f; m_ph = 1; end
          1: if (mem_req_rdy_i) begin m_ph = 2; m_got = 0; m_drop = flush_i; end
             else if (flush_i) m_ph = 0;
          2: begin
            if (flush_i) m_drop = 1;
            if (mem_rdata_vld_i) begin
              m_beats[m_got] = mem_rdata_i;
              m_got++;
              if (m_got == NB) begin m_got = 0; m_ph = 3; end
            end
          end
          default: begin m_ph = 0; m_drop = 0; end
        endcase
      end
    end
  end

  task automatic noise();
    mem_rdata_vld_i = 1'($urandom % 2);
    mem_rdata_i     = {$urandom, $urandom};
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic run_txn(input logic [AW-1:0] addr, input logic rd, input int rdy_wait,
                         input int gap_lo, input int gap_hi, input int flush_beat,
                         input bit flush_hs, input int rst_beat, input int pre_flush,
                         input bit seq_data);
    logic [LS-1:0] line;
    logic [BW-1:0] beat;
    int resp0, n, gap;
    bit ok;
    resp0 = dut_resp_cnt;
    line = '0;
    l1req_vld_i = 1'b1; l1req_addr_i = addr; l1req_rd_i = rd;
    ok = 0;
    for (n = 0; n <= pre_flush + 20; n++) begin
      flush_i = (n < pre_flush);
      noise();
      @(negedge clk);
      if (l1req_ack_o) begin ok = 1; break; end
      tick();
    end
    chk("ack_seen", ok, 1'b1);
    if (ok) chk("ack_latency", n, pre_flush);
    tick();
    l1req_vld_i = 1'b0; flush_i = 1'b0;
    l1req_addr_i = {$urandom, $urandom}; l1req_rd_i = 1'($urandom % 2);
    if (!ok) begin mem_rdata_vld_i = 1'b0; return; end
    ok = 0;
    for (int c = 0; c < rdy_wait + 20; c++) begin
      mem_req_rdy_i = (c >= rdy_wait);
      flush_i = flush_hs && (c >= rdy_wait);
      noise();
      @(negedge clk);
      if (mem_req_vld_o && mem_req_rdy_i) begin ok = 1; last_hs_addr = mem_req_addr_o; break; end
      tick();
    end
    chk("burst_handshake", ok, 1'b1);
    if (ok) chk("burst_addr", last_hs_addr, {addr[AW-1:6], 6'b0});
    tick();
    mem_req_rdy_i = 1'b0; flush_i = 1'b0; mem_rdata_vld_i = 1'b0;
    if (!ok) return;
    for (int b = 0; b < NB; b++) begin
      gap = $urandom_range(gap_hi, gap_lo);
      for (int g = 0; g < gap; g++) begin
        mem_rdata_vld_i = 1'b0; mem_req_rdy_i = 1'($urandom % 2);
        tick();
      end
      beat = seq_data ? 64'(64'h11 * (b + 1)) : {$urandom, $urandom};
      line[b*BW +: BW] = beat;
      mem_rdata_vld_i = 1'b1; mem_rdata_i = beat; flush_i = (b == flush_beat);
      if (b == rst_beat) rst = 1'b1;
      tick();
      mem_rdata_vld_i = 1'b0; flush_i = 1'b0; mem_req_rdy_i = 1'b0;
      if (b == rst_beat) begin
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ack", l1req_ack_o, 1'b0);
        chk("rst_mreq", mem_req_vld_o, 1'b0);
        chk("rst_resp", resp_vld_o, 1'b0);
        chk("rst_data", resp_data_o, '0);
        chk("rst_addr", mem_req_addr_o, '0);
        tick();
        for (int s = 0; s < 3; s++) begin
          mem_rdata_vld_i = 1'b1; mem_rdata_i = {$urandom, $urandom};
          tick();
        end
        mem_rdata_vld_i = 1'b0;
        tick();
        chk("rst_no_resp", dut_resp_cnt, resp0);
        chk("rst_stray_ignored", resp_data_o, '0);
        return;
      end
    end
    noise();
    tick();
    mem_rdata_vld_i = 1'b0;
    if (flush_beat < 0 && !flush_hs) begin
      chk("resp_count", dut_resp_cnt, resp0 + 1);
      chk("line", resp_data_o, line);
    end else begin
      chk("flushed_no_resp", dut_resp_cnt, resp0);
    end
  endtask

  task automatic flush_in_req(input logic [AW-1:0] addr, input int wait_c);
    int hs0, resp0;
    bit ok;
    hs0 = dut_hs_cnt; resp0 = dut_resp_cnt;
    l1req_vld_i = 1'b1; l1req_addr_i = addr; l1req_rd_i = 1'b1;
    ok = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (l1req_ack_o) begin ok = 1; break; end
      tick();
    end
    chk("freq_ack_seen", ok, 1'b1);
    tick();
    l1req_vld_i = 1'b0; mem_req_rdy_i = 1'b0;
    for (int w = 0; w < wait_c; w++) begin noise(); tick(); end
    flush_i = 1'b1; mem_rdata_vld_i = 1'b0;
    tick();
    flush_i = 1'b0;
    @(negedge clk);
    chk("freq_idle_mreq", mem_req_vld_o, 1'b0);
    repeat (3) tick();
    chk("freq_no_handshake", dut_hs_cnt, hs0);
    chk("freq_no_resp", dut_resp_cnt, resp0);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int fb;
    bit fh;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_data", resp_data_o, '0);
    chk("reset_mreq", mem_req_vld_o, 1'b0);
    chk("reset_resp", resp_vld_o, 1'b0);
    tick();

    // Minimum-latency read with sequential beats.
    run_txn(64'h8000_1234, 1'b1, 0, 0, 0, -1, 0, -1, 0, 1);
    chk("t1_latency", dut_resp_cyc - dut_ack_cyc, 10);
    chk("t1_addr", last_hs_addr, 64'h8000_1200);
    chk("t1_beat0", resp_data_o[63:0], 64'h11);
    chk("t1_beat7", resp_data_o[511:448], 64'h88);

    // Slow memory: rdy late, 2-cycle beat gaps.
    run_txn({$urandom, $urandom}, 1'b1, 5, 2, 2, -1, 0, -1, 0, 0);

    // Flush before burst acceptance, then a normal request.
    flush_in_req(64'h1234_5678_9abc_def0, 3);
    run_txn({$urandom, $urandom}, 1'b1, 0, 0, 1, -1, 0, -1, 0, 0);

    // Flush at beat 3, then back-to-back request.
    run_txn({$urandom, $urandom}, 1'b1, 1, 0, 1, 3, 0, -1, 0, 0);
    run_txn({$urandom, $urandom}, 1'b0, 0, 0, 0, -1, 0, -1, 0, 0);

    // Request held while flush is high in IDLE.
    run_txn({$urandom, $urandom}, 1'b1, 0, 0, 0, -1, 0, -1, 3, 0);

    // Reset at beat 5, then a write-allocate request.
    run_txn({$urandom, $urandom}, 1'b1, 0, 0, 1, -1, 0, 5, 0, 0);
    run_txn({$urandom, $urandom}, 1'b0, 2, 0, 1, -1, 0, -1, 0, 1);

    for (int t = 0; t < 30; t++) begin
      fb = -1; fh = 0;
      case ($urandom % 5)
        0: fb = $urandom_range(NB - 1, 0);
        1: fh = 1;
        default: ;
      endcase
      run_txn({$urandom, $urandom}, 1'($urandom % 2), $urandom_range(4, 0), 0,
              $urandom_range(2, 0), fb, fh, -1, $urandom_range(2, 0), 0);
      if ($urandom % 4 == 0) flush_in_req({$urandom, $urandom}, $urandom_range(3, 0));
    end

    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
